// File: rtl/pe_array_ctrl.sv
// Sequencer for one pe_array column: streams A/B reads per pass,
// marks first/last beats and schedules the delayed output-buffer writes.
module pe_array_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int K_WIDTH    = 8,
    parameter int N_WIDTH    = 8,
    parameter int WB_LAT     = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [K_WIDTH-1:0]    k_i,
    input  logic [N_WIDTH-1:0]    n_i,
    input  logic [ADDR_WIDTH-1:0] a_base_i,
    input  logic [ADDR_WIDTH-1:0] b_base_i,
    input  logic [ADDR_WIDTH-1:0] c_base_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  a_rd_en_o,
    output logic [ADDR_WIDTH-1:0] a_addr_o,
    output logic                  b_rd_en_o,
    output logic [ADDR_WIDTH-1:0] b_addr_o,
    output logic                  clr_o,
    output logic                  we_o,
    output logic                  c_wr_en_o,
    output logic [ADDR_WIDTH-1:0] c_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [K_WIDTH-1:0]    k_q, k_d;
    logic [N_WIDTH-1:0]    n_q, n_d;
    logic [ADDR_WIDTH-1:0] a_base_q, a_base_d;
    logic [ADDR_WIDTH-1:0] b_base_q, b_base_d;
    logic [ADDR_WIDTH-1:0] c_base_q, c_base_d;
    logic [K_WIDTH-1:0]    beat_q, beat_d;
    logic [N_WIDTH-1:0]    pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] lin_q, lin_d;
    logic [N_WIDTH-1:0]    wr_idx_q, wr_idx_d;
    logic                  clr_q, clr_d;
    logic                  we_q, we_d;
    logic [WB_LAT-1:0]     wb_q, wb_d;

    logic run;
    logic last_beat;
    logic last_pass;
    logic cfg_ok;

    assign run       = (state_q == S_RUN);
    assign last_beat = (beat_q == k_q - K_WIDTH'(1));
    assign last_pass = (pass_q == n_q - N_WIDTH'(1));
    assign cfg_ok    = (k_i != '0) && (n_i != '0);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        c_base_d = c_base_q;
        beat_d   = beat_q;
        pass_d   = pass_q;
        lin_d    = lin_q;
        wr_idx_d = wr_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && cfg_ok) begin
                    state_d  = S_RUN;
                    k_d      = k_i;
                    n_d      = n_i;
                    a_base_d = a_base_i;
                    b_base_d = b_base_i;
                    c_base_d = c_base_i;
                    beat_d   = '0;
                    pass_d   = '0;
                    lin_d    = '0;
                    wr_idx_d = '0;
                end else if (start_i) begin
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                if (last_beat && last_pass) begin
                    // counters freeze so addresses hold the last issued beat
                    state_d = S_DRAIN;
                end else begin
                    lin_d = lin_q + ADDR_WIDTH'(1);
                    if (last_beat) begin
                        beat_d = '0;
                        pass_d = pass_q + N_WIDTH'(1);
                    end else begin
                        beat_d = beat_q + K_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (c_wr_en_o && wr_idx_q == n_q - N_WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (c_wr_en_o) begin
            wr_idx_d = wr_idx_q + N_WIDTH'(1);
        end
    end

    // read data arrives one cycle after issue, so beat markers are delayed
    assign clr_d = run && (beat_q == '0);
    assign we_d  = run && last_beat;
    assign wb_d  = WB_LAT'({wb_q, we_q});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            n_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            beat_q   <= '0;
            pass_q   <= '0;
            lin_q    <= '0;
            wr_idx_q <= '0;
            clr_q    <= 1'b0;
            we_q     <= 1'b0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            c_base_q <= c_base_d;
            beat_q   <= beat_d;
            pass_q   <= pass_d;
            lin_q    <= lin_d;
            wr_idx_q <= wr_idx_d;
            clr_q    <= clr_d;
            we_q     <= we_d;
            wb_q     <= wb_d;
        end
    end

    assign busy_o    = run || (state_q == S_DRAIN);
    assign done_o    = (state_q == S_DONE);
    assign a_rd_en_o = run;
    assign b_rd_en_o = run;
    assign a_addr_o  = a_base_q + lin_q;
    assign b_addr_o  = b_base_q + ADDR_WIDTH'(beat_q);
    assign clr_o     = clr_q;
    assign we_o      = we_q;
    assign c_wr_en_o = wb_q[WB_LAT-1];
    assign c_addr_o  = c_base_q + ADDR_WIDTH'(wr_idx_q);

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
- Sequencer for one `pe_array` column plus its global buffers.
- Runs a job of N passes. Each pass streams K beats of A words and B data into the array.
- Drives `clr` on the first beat of each pass and `we` on the last beat.
- Issues the output-buffer write for each pass once the assembled output word has settled.

Parameters:
- ADDR_WIDTH, 16, width of all buffer addresses.
- K_WIDTH, 8, width of beats-per-pass count.
- N_WIDTH, 8, width of pass count.
- WB_LAT, 12, cycles from we_o assertion until the array's output word is stable; must be >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  job start pulse; sampled only in IDLE.
- k_i  in  K_WIDTH  beats per pass; latched at start.
- n_i  in  N_WIDTH  passes per job; latched at start.
- a_base_i  in  ADDR_WIDTH  A buffer base address; latched.
- b_base_i  in  ADDR_WIDTH  B buffer base address; latched.
- c_base_i  in  ADDR_WIDTH  output buffer base address; latched.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle job completion pulse.
- a_rd_en_o  out  1  A buffer read enable.
- a_addr_o  out  ADDR_WIDTH  A read address.
- b_rd_en_o  out  1  B buffer read enable.
- b_addr_o  out  ADDR_WIDTH  B read address.
- clr_o  out  1  array clear, aligned with first-beat read data.
- we_o  out  1  array write enable, aligned with last-beat read data.
- c_wr_en_o  out  1  output buffer write enable (data = array output word).
- c_addr_o  out  ADDR_WIDTH  output write address.

Behaviour:
- Reset:
  - All outputs 0, state IDLE.
  - Beat, pass and write counters cleared; writeback delay line cleared.
  - Reset mid-job aborts the job: no further reads or writes, and no done_o.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start_i=1 with k_i!=0 and n_i!=0: latch all config, go to RUN.
  - On start_i=1 with k_i==0 or n_i==0: go directly to DONE; no reads or writes.
  - busy_o=0.
- RUN:
  - Every cycle, a_rd_en_o=b_rd_en_o=1.
  - a_addr_o = a_base + pass*K + beat, from a linear counter that does not restart per pass.
  - b_addr_o = b_base + beat; the beat counter restarts each pass.
  - Beat counts 0..K-1, then wraps to 0 and pass increments.
  - After issuing beat K-1 of pass N-1, go to DRAIN.
- Buffers have 1-cycle read latency, so clr_o and we_o are registered copies of (beat==0) and (beat==K-1) from the issue cycle.
  - With K=1, clr_o and we_o assert in the same cycle.
  - Passes run back-to-back with no bubble: the we_o of pass p and the clr_o of pass p+1 are in consecutive cycles.
- Writeback:
  - Each we_o pulse enters a WB_LAT-deep shift register.
  - Its output drives c_wr_en_o, so the write lands exactly WB_LAT cycles after the corresponding we_o.
  - c_addr_o = c_base + write index; the index increments after each write.
  - Multiple passes may be in flight when K < WB_LAT.
- DRAIN: wait until the N-th c_wr_en_o has been issued, then go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - busy_o=0 in the DONE cycle.
  - busy_o=1 in RUN and DRAIN.
- Timing, with start sampled at edge 0:
  - First read in cycle 1; first clr_o in cycle 2.
  - we_o of pass p in cycle 1+(p+1)*K.
  - Last c_wr_en_o in cycle 1+N*K+WB_LAT.
  - done_o in cycle 2+N*K+WB_LAT.
- start_i while busy is ignored; latched config is unaffected.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; there is no overflow flag.
- Read enables are 0 outside RUN.
- Address outputs hold their last value when idle and are don't-care when their enable is 0.

Test Plan:
- N=1, K=1, WB_LAT=12, bases 0x10/0x20/0x30 → read at cycle 1 (a=0x10, b=0x20); clr_o=we_o=1 at cycle 2; c_wr_en_o at cycle 14 with c_addr=0x30; done_o at cycle 15.
- N=3, K=4 → 12 consecutive reads with a_addr 0..11 and b_addr cycling 0..3.
  - clr_o at cycles 2,6,10; we_o at cycles 5,9,13.
  - Writes at cycles 17,21,25 to c_base+0,1,2; done_o at 26.
- N=4, K=2 (K<WB_LAT) → we_o at 3,5,7,9; writes at 15,17,19,21 with addresses +0..+3; no write dropped or merged.
- start_i pulsed again during RUN with different k_i → ignored; addresses and write count follow the original config.
- k_i=0 (and separately n_i=0) → done_o one cycle after the DONE transition; no rd_en, clr, we or wr_en ever asserted.
- rst_i asserted at cycle 6 of the N=3, K=4 job → next cycle all outputs 0 and no pending writes emerge later; a fresh start then runs normally from pass 0.
